// File: rtl/shift_exec_stage.sv
// Two-stage MIPS shift execute unit (SLL/SRL/SRA and variable forms) with valid/ready flow control.
// Optional rotate support (ROTR/ROTRV) is built when SHIFT_ROTATE_EN is defined.
module shift_exec_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_rot,
    input  logic [31:0]      in_rt,
    input  logic [31:0]      in_rs,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    // Stage A: captured micro-op with the shift amount already resolved
    logic             a_valid_reg;
    logic [1:0]       a_op_reg;
    logic [31:0]      a_rt_reg;
    logic [4:0]       a_amt_reg;
    logic [TAG_W-1:0] a_tag_reg;

    // Stage B: computed result presented to the consumer
    logic             b_valid_reg;
    logic [31:0]      b_result_reg;
    logic [TAG_W-1:0] b_tag_reg;
    logic             b_illegal_reg;

    logic             a_advance;
    logic             capture;
    logic [4:0]       in_amt;
    logic [31:0]      shift_result;
    logic             shift_illegal;

    // op[2] selects the variable form, which takes its amount from rs
    assign in_amt    = in_op[2] ? in_rs[4:0] : in_shamt;
    assign a_advance = !b_valid_reg || out_ready;
    assign in_ready  = !a_valid_reg || a_advance;
    assign capture   = in_valid && in_ready && !flush;

`ifdef SHIFT_ROTATE_EN
    logic        a_rot_reg;
    logic [63:0] rot_wide;
    logic        unused_rs_hi;

    assign unused_rs_hi = ^in_rs[31:5];
    assign rot_wide     = {a_rt_reg, a_rt_reg} >> a_amt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rot_reg <= 1'b0;
        end else if (capture) begin
            a_rot_reg <= in_rot;
        end
    end
`else
    logic unused_inputs;

    assign unused_inputs = ^{in_rs[31:5], in_rot};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_reg <= 1'b0;
            a_op_reg    <= '0;
            a_rt_reg    <= '0;
            a_amt_reg   <= '0;
            a_tag_reg   <= '0;
        end else begin
            if (flush) begin
                a_valid_reg <= 1'b0;
            end else if (in_ready) begin
                a_valid_reg <= in_valid;
            end
            if (capture) begin
                a_op_reg  <= in_op[1:0];
                a_rt_reg  <= in_rt;
                a_amt_reg <= in_amt;
                a_tag_reg <= in_tag;
            end
        end
    end

    // Illegal encodings pass rt through untouched so the writeback slot is still consumed
    always_comb begin
        shift_illegal = (a_op_reg == 2'b01);
`ifdef SHIFT_ROTATE_EN
        if (a_rot_reg && (a_op_reg != 2'b10)) begin
            shift_illegal = 1'b1;
        end
`endif
        shift_result = a_rt_reg;
        if (!shift_illegal) begin
            case (a_op_reg)
                2'b00:   shift_result = a_rt_reg << a_amt_reg;
                2'b10: begin
                    shift_result = a_rt_reg >> a_amt_reg;
`ifdef SHIFT_ROTATE_EN
                    if (a_rot_reg) begin
                        shift_result = rot_wide[31:0];
                    end
`endif
                end
                2'b11:   shift_result = $unsigned($signed(a_rt_reg) >>> a_amt_reg);
                default: shift_result = a_rt_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid_reg   <= 1'b0;
            b_result_reg  <= '0;
            b_tag_reg     <= '0;
            b_illegal_reg <= 1'b0;
        end else begin
            if (flush) begin
                b_valid_reg <= 1'b0;
            end else if (a_advance) begin
                b_valid_reg <= a_valid_reg;
            end
            // Loading only on advance keeps the outputs frozen while stalled
            if (a_advance && a_valid_reg && !flush) begin
                b_result_reg  <= shift_result;
                b_tag_reg     <= a_tag_reg;
                b_illegal_reg <= shift_illegal;
            end
        end
    end

    assign out_valid   = b_valid_reg;
    assign out_result  = b_result_reg;
    assign out_tag     = b_tag_reg;
    assign out_illegal = b_illegal_reg;

endmodule
